eth_rx_ring: RTL and testbench
==============================

// Module: eth_rx_ring
// PURPOSE
// - Parametrised receive-frame ring for the RGMII MAC RX AXI-stream. Generalises the fixed 8-buffer RX path.
// - Filters each frame on destination MAC; drops runt, errored, oversize and ring-full frames.
// - Stores accepted frames in NBUF slots and records each frame's length.
// - Exposes a word-wide host read port, head/tail/count status, drop counters and a level IRQ.
// PARAMETERS
// NBUF       8     number of frame slots; power of 2, range 2..16
// BUF_BYTES  2048  bytes per slot; power of 2, at least 64
// DATA_W     64    host read width in bits: 32 or 64
// MCAST_EN   1     1 = accept IPv4 multicast destinations (01:00:5E:xx:xx:xx)
// PORTS
// clk_int        in   1     single clock for all logic
// rst_int        in   1     synchronous reset, active-high
// rx_tdata       in   8     RX byte from MAC; first byte = MAC byte 0
// rx_tvalid      in   1     byte valid; the stream cannot stall, so there is no tready
// rx_tlast       in   1     last byte of frame
// rx_tuser       in   1     error flag, sampled with tlast
// mac_addr       in   48    local unicast address; mac_addr[47:40] = first byte on the wire
// promiscuous    in   1     accept every destination
// irq_en         in   1     IRQ enable
// rd_en          in   1     host read strobe
// rd_addr        in   log2(NBUF)+log2(BUF_BYTES*8/DATA_W)   {slot, word index}
// rd_data        out  DATA_W  read data, 1-cycle latency; byte 0 of the word in bits [7:0]
// len_idx        in   log2(NBUF)   slot whose length is reported
// len_data       out  log2(BUF_BYTES)+1   stored length of slot len_idx, combinational
// release        in   1     pulse: host has consumed the slot at tail
// head           out  log2(NBUF)   next slot to be written
// tail           out  log2(NBUF)   oldest unread slot
// count          out  log2(NBUF)+1   number of filled slots
// drop_filt      out  16    frames dropped by the address filter; saturating
// drop_full      out  16    frames dropped because the ring was full; saturating
// drop_err       out  16    frames dropped as runt, tuser error or oversize; saturating
// irq            out  1     registered: irq_en & (count != 0)
// BEHAVIOUR
// - Reset: head, tail, count, rd_data, all drop counters, irq and every length entry = 0; FSM = IDLE.
// - FSM states and transitions:
//   - IDLE: on tvalid, if count==NBUF -> DROP and drop_full++; else write byte 0 at offset 0 and go HDR (bcnt=1).
//   - HDR: store bytes, shift them into dst. After the 6th byte is stored, evaluate the filter:
//     - match = promiscuous | dst==all-ones | dst==mac_addr | (MCAST_EN & dst[47:24]==24'h01005E);
//     - match -> BODY; no match -> DROP and drop_filt++.
//   - BODY: store byte at offset bcnt, then bcnt++.
//   - DROP: discard bytes until tlast, then IDLE. Nothing further is counted.
// - Frame end:
//   - tlast in HDR before 6 bytes -> drop_err++, IDLE.
//   - tlast with tuser=1 in HDR or BODY -> drop_err++, IDLE.
//   - Otherwise tlast in BODY commits the frame.
// - A one-byte frame has tlast on byte 0 in IDLE. It is a runt: drop_err++, stay IDLE.
// - Oversize: a byte arriving when bcnt==BUF_BYTES -> drop_err++, DROP.
// - Commit (same edge as the tlast byte):
//   - len[head] <= bcnt+1; head <= head+1, wrapping modulo NBUF; count++.
//   - Length covers every stream byte including the FCS. A full BUF_BYTES frame is legal.
// - Release:
//   - release with count!=0: tail++ (wrapping), count--.
//   - release with count==0 is ignored.
//   - Commit and release on the same cycle: count unchanged, head and tail both advance.
// - Dropped frames never move head; partial data written into slot head is simply overwritten by the next frame.
// - Host reads are legal on any slot at any time; contents of non-filled slots are don't-care.
// - rd_data holds its value while rd_en=0.
// - Counters saturate at 16'hFFFF.
// - irq updates one cycle after count changes.
// - Reset mid-frame: the FSM returns to IDLE, and bytes of the current frame after reset are discarded until tlast.
//   - Implement this as DROP on the first tvalid whose byte is not a frame start.
//   - This requires a post-reset "resync" flag cleared by the first tlast.
// TESTING
// - Frame of 64 bytes to dst=mac_addr -> head=1, count=1, len[0]=64, irq=1 (irq_en=1); slot 0 word 0 = bytes 0..7 LE.
// - Frame to 00:11:22:33:44:55 with promiscuous=0 -> drop_filt=1, head=0; same frame with promiscuous=1 -> accepted.
// - 9 good frames with NBUF=8 and no release -> count=8, drop_full=1; then release -> count=7, tail=1.
// - Frame of BUF_BYTES+1 bytes -> drop_err=1, head unchanged; frame of exactly BUF_BYTES bytes -> len=BUF_BYTES.
// - Frame with tuser=1 on tlast, and a 4-byte runt -> drop_err=2, count=0.
// - Commit on the same cycle as release with count=3 -> count stays 3; release at count=0 -> no change.

Source files
------------

// File: rtl/eth_rx_ring.sv
// Receive-frame ring: filters RX AXI-stream frames on destination MAC, stores accepted
// frames in NBUF slots with their lengths, and exposes a host read port and status.

module eth_rx_ring #(
    parameter int unsigned  NBUF      = 8,
    parameter int unsigned  BUF_BYTES = 2048,
    parameter int unsigned  DATA_W    = 64,
    parameter bit           MCAST_EN  = 1'b1,
    localparam int unsigned SW        = $clog2(NBUF),
    localparam int unsigned OW        = $clog2(BUF_BYTES),
    localparam int unsigned LBW       = $clog2(DATA_W / 8),
    localparam int unsigned AW        = SW + OW - LBW
) (
    input  logic              clk_int,
    input  logic              rst_int,
    input  logic [7:0]        rx_tdata,
    input  logic              rx_tvalid,
    input  logic              rx_tlast,
    input  logic              rx_tuser,
    input  logic [47:0]       mac_addr,
    input  logic              promiscuous,
    input  logic              irq_en,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [SW-1:0]     len_idx,
    output logic [OW:0]       len_data,
    input  logic              release_slot,
    output logic [SW-1:0]     head,
    output logic [SW-1:0]     tail,
    output logic [SW:0]       count,
    output logic [15:0]       drop_filt,
    output logic [15:0]       drop_full,
    output logic [15:0]       drop_err,
    output logic              irq
);

    typedef enum logic [1:0] {StIdle, StHdr, StBody, StDrop} state_t;

    state_t      state_q, state_d;
    logic [OW:0] bcnt_q, bcnt_d;
    logic [47:0] dst_q, dst_d, dst_nxt;
    logic [OW:0] len_q [NBUF];
    logic        mid_frame_q;
    logic        commit, ev_err, ev_full, ev_filt, wr_en, rel_ok, match;
    logic [OW-1:0]     wr_off;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] mem [1 << AW];

    assign dst_nxt  = {dst_q[39:0], rx_tdata};
    assign match    = promiscuous || (dst_nxt == 48'hFFFF_FFFF_FFFF) || (dst_nxt == mac_addr) ||
                      (MCAST_EN && (dst_nxt[47:24] == 24'h01005E));
    assign rel_ok   = release_slot && (count != '0);
    assign wr_off   = (state_q == StIdle) ? '0 : bcnt_q[OW-1:0];
    assign wr_addr  = {head, wr_off[OW-1:LBW]};
    assign len_data = len_q[len_idx];

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        dst_d   = dst_q;
        commit  = 1'b0;
        ev_err  = 1'b0;
        ev_full = 1'b0;
        ev_filt = 1'b0;
        wr_en   = 1'b0;
        if (rx_tvalid) begin
            unique case (state_q)
                StIdle: begin
                    if (mid_frame_q) begin
                        state_d = rx_tlast ? StIdle : StDrop;
                    end else if (count == (SW+1)'(NBUF)) begin
                        ev_full = 1'b1;
                        state_d = rx_tlast ? StIdle : StDrop;
                    end else if (rx_tlast) begin
                        ev_err = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        state_d = StHdr;
                        bcnt_d  = (OW+1)'(1);
                        dst_d   = dst_nxt;
                    end
                end
                StHdr: begin
                    wr_en  = 1'b1;
                    dst_d  = dst_nxt;
                    bcnt_d = bcnt_q + (OW+1)'(1);
                    if (rx_tlast) begin
                        ev_err  = 1'b1;
                        state_d = StIdle;
                    end else if (bcnt_q == (OW+1)'(5)) begin
                        ev_filt = !match;
                        state_d = match ? StBody : StDrop;
                    end
                end
                StBody: begin
                    // bcnt_q[OW] set means the slot is already full
                    if (bcnt_q[OW]) begin
                        ev_err  = 1'b1;
                        state_d = rx_tlast ? StIdle : StDrop;
                    end else begin
                        wr_en  = 1'b1;
                        bcnt_d = bcnt_q + (OW+1)'(1);
                        if (rx_tlast) begin
                            state_d = StIdle;
                            ev_err  = rx_tuser;
                            commit  = !rx_tuser;
                        end
                    end
                end
                StDrop: begin
                    if (rx_tlast) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_int) begin
        if (rst_int) begin
            state_q   <= StIdle;
            bcnt_q    <= '0;
            dst_q     <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            drop_filt <= '0;
            drop_full <= '0;
            drop_err  <= '0;
            irq       <= 1'b0;
            for (int i = 0; i < NBUF; i++) len_q[i] <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            dst_q   <= dst_d;
            irq     <= irq_en && (count != '0);
            if (commit) begin
                len_q[head] <= bcnt_q + (OW+1)'(1);
                head        <= head + SW'(1);
            end
            if (rel_ok) tail <= tail + SW'(1);
            if (commit && !rel_ok) count <= count + (SW+1)'(1);
            if (!commit && rel_ok) count <= count - (SW+1)'(1);
            if (ev_filt && drop_filt != 16'hFFFF) drop_filt <= drop_filt + 16'd1;
            if (ev_full && drop_full != 16'hFFFF) drop_full <= drop_full + 16'd1;
            if (ev_err && drop_err != 16'hFFFF) drop_err <= drop_err + 16'd1;
        end
    end

    // Tracks the wire through reset so a frame cut by reset is discarded up to its tlast
    always_ff @(posedge clk_int) begin
        if (rx_tvalid) mid_frame_q <= !rx_tlast;
    end

    always_ff @(posedge clk_int) begin
        if (wr_en) mem[wr_addr][{wr_off[LBW-1:0], 3'b000} +: 8] <= rx_tdata;
    end

    always_ff @(posedge clk_int) begin
        if (rst_int) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_eth_rx_ring.sv
// Randomised bench for eth_rx_ring: a frame-level reference model feeds expected status and
// read data into queues that a monitor process checks against the DUT outputs.

module tb_eth_rx_ring;

    localparam int NBUF = 8;
    localparam int BB   = 256;
    localparam int DW   = 64;
    localparam int SW   = 3;
    localparam int OW   = 8;
    localparam int AW   = 8;
    localparam int WPS  = BB * 8 / DW;
    localparam logic [47:0] MAC   = 48'h02AA_BBCC_DDEE;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MCAST = 48'h0100_5E12_3456;
    localparam logic [47:0] OTHER = 48'h0011_2233_4455;

    logic          clk_int = 1'b0;
    logic          rst_int, rx_tvalid, rx_tlast, rx_tuser, promiscuous, irq_en, rd_en;
    logic          release_slot, irq;
    logic [7:0]    rx_tdata;
    logic [47:0]   mac_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [SW-1:0] len_idx, head, tail;
    logic [OW:0]   len_data;
    logic [SW:0]   count;
    logic [15:0]   drop_filt, drop_full, drop_err;

    eth_rx_ring #(.NBUF(NBUF), .BUF_BYTES(BB), .DATA_W(DW), .MCAST_EN(1'b1)) dut (
        .clk_int(clk_int), .rst_int(rst_int), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser), .mac_addr(mac_addr), .promiscuous(promiscuous),
        .irq_en(irq_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .len_idx(len_idx),
        .len_data(len_data), .release_slot(release_slot), .head(head), .tail(tail),
        .count(count), .drop_filt(drop_filt), .drop_full(drop_full), .drop_err(drop_err),
        .irq(irq)
    );

    always #5 clk_int = ~clk_int;

    typedef struct {
        int head; int tail; int count; int filt; int full; int err; int irq; int len; bit chk_rd;
    } st_t;
    typedef struct { logic [63:0] exp; logic [63:0] mask; } rd_t;

    st_t st_q[$];
    rd_t rd_q[$];
    logic [7:0] frm[$];
    logic       st_req = 1'b0;
    logic       rd_fire = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_head, m_tail, m_count, m_filt, m_full, m_err;
    int m_len [NBUF];
    logic [7:0] m_mem [NBUF][BB];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk_int) rd_fire <= rd_en;

    always @(negedge clk_int) begin
        if (rd_fire) begin
            if (rd_q.size() == 0) cmp("rd_underflow", 64'd1, 64'd0);
            else begin
                rd_t r;
                r = rd_q.pop_front();
                cmp("rd_data", rd_data & r.mask, r.exp & r.mask);
            end
        end
        if (st_req) begin
            if (st_q.size() == 0) cmp("st_underflow", 64'd1, 64'd0);
            else begin
                st_t s;
                s = st_q.pop_front();
                cmp("head", 64'(head), 64'(s.head));
                cmp("tail", 64'(tail), 64'(s.tail));
                cmp("count", 64'(count), 64'(s.count));
                cmp("drop_filt", 64'(drop_filt), 64'(s.filt));
                cmp("drop_full", 64'(drop_full), 64'(s.full));
                cmp("drop_err", 64'(drop_err), 64'(s.err));
                cmp("irq", 64'(irq), 64'(s.irq));
                cmp("len_data", 64'(len_data), 64'(s.len));
                if (s.chk_rd) cmp("rd_data_reset", rd_data, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_int);
        #1;
        rx_tvalid    = 1'b0;
        rx_tlast     = 1'b0;
        rx_tuser     = 1'b0;
        rd_en        = 1'b0;
        st_req       = 1'b0;
        release_slot = 1'b0;
    endtask

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_count = 0; m_filt = 0; m_full = 0; m_err = 0;
        for (int i = 0; i < NBUF; i++) m_len[i] = 0;
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_frame(input bit tuser, input bit rel);
        int n, cb;
        logic [47:0] d;
        bit hit;
        n  = frm.size();
        cb = m_count;
        if (m_count == NBUF) m_full = sat(m_full);
        else if (n <= 6) m_err = sat(m_err);
        else begin
            d   = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
            hit = promiscuous || d == BCAST || d == mac_addr || d[47:24] == 24'h01005E;
            if (!hit) m_filt = sat(m_filt);
            else if (tuser || n > BB) m_err = sat(m_err);
            else begin
                for (int i = 0; i < n; i++) m_mem[m_head][i] = frm[i];
                m_len[m_head] = n;
                m_head = (m_head + 1) % NBUF;
                m_count++;
            end
        end
        if (rel && cb != 0) begin
            m_tail = (m_tail + 1) % NBUF;
            m_count--;
        end
    endtask

    task automatic gen_frame(input logic [47:0] dst, input int n);
        frm.delete();
        for (int i = 0; i < n; i++) begin
            if (i < 6) frm.push_back(dst[47-8*i -: 8]);
            else frm.push_back(8'($urandom));
        end
    endtask

    task automatic send_frame(input bit tuser, input bit rel, input bit gaps);
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps && $urandom_range(0, 15) == 0) tick();
            tick();
            rx_tvalid = 1'b1;
            rx_tdata  = frm[i];
            if (i == frm.size() - 1) begin
                rx_tlast     = 1'b1;
                rx_tuser     = tuser;
                release_slot = rel;
            end
        end
        model_frame(tuser, rel);
    endtask

    task automatic do_release();
        tick();
        release_slot = 1'b1;
        if (m_count != 0) begin
            m_tail = (m_tail + 1) % NBUF;
            m_count--;
        end
    endtask

    task automatic check_status(input int lidx, input bit chk_rd);
        st_t s;
        repeat (3) tick();
        st_req  = 1'b1;
        len_idx = SW'(lidx);
        s = '{head: m_head, tail: m_tail, count: m_count, filt: m_filt, full: m_full,
              err: m_err, irq: int'(irq_en && m_count != 0), len: m_len[lidx], chk_rd: chk_rd};
        st_q.push_back(s);
    endtask

    task automatic check_read(input int slot, input int word);
        rd_t r;
        r.exp = '0; r.mask = '0;
        for (int b = 0; b < 8; b++) begin
            if (word * 8 + b < m_len[slot]) begin
                r.exp[8*b +: 8]  = m_mem[slot][word*8+b];
                r.mask[8*b +: 8] = 8'hFF;
            end
        end
        tick();
        rd_en   = 1'b1;
        rd_addr = AW'(slot * WPS + word);
        rd_q.push_back(r);
    endtask

    task automatic good_frame(input int n, input bit rel);
        logic [47:0] d;
        int k;
        k = $urandom_range(0, 2);
        d = (k == 0) ? MAC : (k == 1) ? BCAST : MCAST;
        gen_frame(d, n);
        send_frame(1'b0, rel, 1'b1);
    endtask

    task automatic random_reads();
        int slot;
        for (int i = 0; i < 2; i++) begin
            if (m_count > 0) begin
                slot = (m_tail + $urandom_range(0, m_count - 1)) % NBUF;
                check_read(slot, $urandom_range(0, (m_len[slot] - 1) / 8));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        logic [47:0] d;
        rst_int = 1'b1; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; rx_tdata = '0;
        mac_addr = MAC; promiscuous = 1'b0; irq_en = 1'b1; rd_en = 1'b0; rd_addr = '0;
        len_idx = '0; release_slot = 1'b0;
        repeat (3) tick();
        rst_int = 1'b0;
        model_reset();
        check_status(0, 1'b1);

        gen_frame(MAC, 64);
        send_frame(1'b0, 1'b0, 1'b0);
        check_status(0, 1'b0);
        check_read(0, 0);
        check_read(0, 7);

        gen_frame(OTHER, 64);
        send_frame(1'b0, 1'b0, 1'b0);
        check_status(1, 1'b0);
        promiscuous = 1'b1;
        send_frame(1'b0, 1'b0, 1'b0);
        promiscuous = 1'b0;
        check_status(1, 1'b0);
        check_read(1, 3);

        do_release();
        do_release();
        for (int i = 0; i < 9; i++) good_frame(60 + i, 1'b0);
        check_status(3, 1'b0);
        do_release();
        check_status(2, 1'b0);
        while (m_count > 0) do_release();

        gen_frame(MAC, BB + 1);
        send_frame(1'b0, 1'b0, 1'b0);
        check_status(m_head, 1'b0);
        gen_frame(MAC, BB);
        send_frame(1'b0, 1'b0, 1'b0);
        check_status((m_head + NBUF - 1) % NBUF, 1'b0);
        check_read((m_head + NBUF - 1) % NBUF, WPS - 1);

        gen_frame(MAC, 70);
        send_frame(1'b1, 1'b0, 1'b0);
        gen_frame(MAC, 4);
        send_frame(1'b0, 1'b0, 1'b0);
        gen_frame(MAC, 1);
        send_frame(1'b0, 1'b0, 1'b0);
        check_status(0, 1'b0);

        while (m_count > 3) do_release();
        while (m_count < 3) good_frame(64, 1'b0);
        good_frame(72, 1'b1);
        check_status(m_tail, 1'b0);
        while (m_count > 0) do_release();
        do_release();
        check_status(m_tail, 1'b0);

        // Reset in the middle of a frame: its remaining bytes must be discarded
        gen_frame(MAC, 64);
        for (int i = 0; i < 20; i++) begin
            tick(); rx_tvalid = 1'b1; rx_tdata = frm[i];
        end
        tick(); rst_int = 1'b1; rx_tvalid = 1'b1; rx_tdata = frm[20];
        tick(); rst_int = 1'b0;
        model_reset();
        for (int i = 21; i < 64; i++) begin
            tick(); rx_tvalid = 1'b1; rx_tdata = frm[i]; rx_tlast = (i == 63);
        end
        check_status(0, 1'b0);
        good_frame(66, 1'b0);
        check_status(0, 1'b0);
        check_read(0, 8);

        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 9);
            n = (k == 0) ? $urandom_range(1, 6) : (k == 1) ? BB : (k == 2) ? BB + 1 :
                $urandom_range(7, 80);
            k = $urandom_range(0, 3);
            d = (k == 0) ? MAC : (k == 1) ? BCAST :
                (k == 2) ? {24'h01005E, 24'($urandom)} : {8'h02, 40'($urandom)};
            promiscuous = ($urandom_range(0, 4) == 0);
            gen_frame(d, n);
            send_frame($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, 1'b1);
            k = $urandom_range(0, 3);
            if (k == 0) begin do_release(); do_release(); end
            else if (k == 1) do_release();
            irq_en = ($urandom_range(0, 3) != 0);
            check_status($urandom_range(0, NBUF - 1), 1'b0);
            random_reads();
        end

        repeat (4) tick();
        cmp("rd_queue_left", 64'(rd_q.size()), 64'd0);
        cmp("st_queue_left", 64'(st_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
